decgray: RTL



---
 rtl/decgray_pkg.sv | 15 +
 rtl/gray2bin.sv | 17 +
 rtl/decgray.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decgray_pkg.sv
// Shared definitions for the Gray/binary receive-side decoder: step
// classification codes and tracker states.
package decgray_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [1:0] DIR_JMP  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/gray2bin.sv
// Reflected Gray to binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] g_i,
  output logic [W-1:0] b_o
);

  always_comb begin
    b_o = '0;
    for (int k = 0; k < W; k++) begin
      b_o[k] = ^(g_i >> k);
    end
  end

endmodule

// File: rtl/decgray.sv
// Decoder/monitor for the counter bus: decodes each accepted sample, classifies
// the step against the previous one, counts steps and flags Gray breaks.
module decgray
  import decgray_pkg::*;
#(
  parameter int W  = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [W-1:0]  d,
  input  logic          esgray,
  input  logic          v,
  output logic [W-1:0]  b,
  output logic [1:0]    dir,
  output logic          nuevo,
  output logic          brinco,
  output logic [PW-1:0] pasos,
  output logic          err,
  output logic          listo
);

  // Handshake: there is no backpressure; a sample is consumed on every rising
  // edge where v=1, and its results appear one cycle later with nuevo=1.

  state_e        state_q, state_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    dir_q, dir_d;
  logic          nuevo_q, nuevo_d;
  logic          brinco_q, brinco_d;
  logic [PW-1:0] pasos_q, pasos_d;
  logic          err_q, err_d;
  logic [W-1:0]  praw_q, praw_d;
  logic [W-1:0]  pbin_q, pbin_d;
  logic          pmode_q, pmode_d;

  logic [W-1:0]  gray_bin;
  logic [W-1:0]  bin;
  logic [W-1:0]  delta;
  logic [W-1:0]  flips;
  logic          multi_flip;
  logic          first;

  gray2bin #(.W(W)) u_gray2bin (
    .g_i (d),
    .b_o (gray_bin)
  );

  assign bin   = esgray ? gray_bin : d;
  assign delta = bin - pbin_q;
  assign flips = d ^ praw_q;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_flip = |(flips & (flips - W'(1)));
  assign first = (state_q == IDLE) || (esgray != pmode_q);

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    dir_d    = dir_q;
    nuevo_d  = 1'b0;
    brinco_d = 1'b0;
    pasos_d  = pasos_q;
    err_d    = err_q;
    praw_d   = praw_q;
    pbin_d   = pbin_q;
    pmode_d  = pmode_q;
    if (v) begin
      state_d = TRACK;
      b_d     = bin;
      nuevo_d = 1'b1;
      praw_d  = d;
      pbin_d  = bin;
      pmode_d = esgray;
      if (first) begin
        dir_d = DIR_HOLD;
      end else begin
        if (delta == '0) begin
          dir_d = DIR_HOLD;
        end else if (delta == W'(1)) begin
          dir_d = DIR_UP;
        end else if (delta == '1) begin
          dir_d = DIR_DN;
        end else begin
          dir_d    = DIR_JMP;
          brinco_d = 1'b1;
        end
        if ((dir_d == DIR_UP || dir_d == DIR_DN) && pasos_q != '1) begin
          pasos_d = pasos_q + PW'(1);
        end
        if (esgray && multi_flip) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      b_q      <= '0;
      dir_q    <= DIR_HOLD;
      nuevo_q  <= 1'b0;
      brinco_q <= 1'b0;
      pasos_q  <= '0;
      err_q    <= 1'b0;
      praw_q   <= '0;
      pbin_q   <= '0;
      pmode_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      dir_q    <= dir_d;
      nuevo_q  <= nuevo_d;
      brinco_q <= brinco_d;
      pasos_q  <= pasos_d;
      err_q    <= err_d;
      praw_q   <= praw_d;
      pbin_q   <= pbin_d;
      pmode_q  <= pmode_d;
    end
  end

  assign b      = b_q;
  assign dir    = dir_q;
  assign nuevo  = nuevo_q;
  assign brinco = brinco_q;
  assign pasos  = pasos_q;
  assign err    = err_q;
  assign listo  = (state_q == TRACK);

endmodule
